rr_arb4: RTL and testbench
==========================

RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter N, default 8, data width of every data input and of y.
REQ-002 clk  input  1  single clock for the block; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  req[i]=1: source i presents valid data on di.
REQ-005 d0  input  N  data of source 0.
REQ-006 d1  input  N  data of source 1.
REQ-007 d2  input  N  data of source 2.
REQ-008 d3  input  N  data of source 3.
REQ-009 gnt  output  4  one-hot, combinational; gnt[i]=1 means di is captured on this rising edge.
REQ-010 s  output  2  registered index of the source currently held in y.
REQ-011 y  output  N  registered selected data.
REQ-012 y_valid  output  1  y holds data not yet accepted downstream.
REQ-013 y_ready  input  1  downstream accepts y when y_valid and y_ready are both 1 on a rising edge.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE (y_valid=0) and BUSY (y_valid=1).
REQ-015 load SHALL be defined as (any req) and (state IDLE, or state BUSY with y_ready=1).
REQ-016 The winner SHALL be the first i with req[i]=1 scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-017 On load, the block SHALL raise gnt[winner] for that cycle only, and on the edge SHALL set y<=d[winner], s<=winner, ptr<=winner+1 (mod 4, 3 wraps to 0), and state<=BUSY.
REQ-018 gnt SHALL be all-zero whenever load is 0.
REQ-019 In BUSY with y_ready=1 and no req, the block SHALL go to IDLE; y and s SHALL hold their values.
REQ-020 In BUSY with y_ready=0, y, s, ptr and state SHALL hold, regardless of req.
REQ-021 In IDLE, y_ready SHALL be ignored.
REQ-022 Latency from req sampled in IDLE to y_valid=1 SHALL be one clock.
REQ-023 With continuous y_ready=1 and at least one req, the block SHALL load every cycle (full throughput).
REQ-024 The selection and ptr update SHALL be performed in width-2 modular arithmetic with no overflow state.

Reset
REQ-025 While rst=1, the block SHALL asynchronously force state=IDLE, y_valid=0, y=0, s=2'b00, ptr=2'b00.
REQ-026 gnt SHALL be 4'b0000 while rst=1.
REQ-027 Reset asserted mid-transfer SHALL discard the held word without asserting gnt.
REQ-028 After rst deasserts, the first load SHALL give priority to source 0.

Structure
REQ-029 The FSM state encodings (IDLE=1'b0, BUSY=1'b1) and the source count constant (4) SHALL live in the shared definitions package/header.
REQ-030 The data path SHALL instantiate the existing 4:1 mux sub-module mux4 (parameter N), driven by the combinational winner index.
REQ-031 The block SHALL NOT contain a second copy of the mux logic.

Verification
REQ-032 Reset, then req=4'b0100, d2=8'hA5, y_ready=0 -> gnt=4'b0100 for one cycle; next cycle y=8'hA5, s=2, y_valid=1; y holds while y_ready=0.
REQ-033 req=4'b1111 held, y_ready=1, distinct d values -> s sequence 0,1,2,3,0, one per clock, with gnt one-hot each cycle.
REQ-034 BUSY with s=3, y_ready=0 for 5 cycles, req=4'b0001 -> gnt=0 and y stable; on y_ready=1, gnt=4'b0001 and next s=0 (ptr wrap).
REQ-035 BUSY, y_ready=1, req=0 -> y_valid=0 next cycle, y and s unchanged; a later req=4'b1000 gives y_valid=1 one clock later.
REQ-036 Assert rst asynchronously mid-cycle while BUSY -> y_valid=0 and gnt=0 immediately, with no clock edge; after release, req=4'b1111 grants source 0 first.

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// rr_arb4_pkg: shared FSM encodings, source count and round-robin pick helper.
package rr_arb4_pkg;

    localparam int NSRC = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // First requesting index scanning ptr, ptr+1, ... in 2-bit wrap-around order.
    function automatic logic [1:0] rr_pick(input logic [NSRC-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] w;
        w = ptr;
        for (int k = NSRC - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) w = idx;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arb4_mux4.sv
// mux4: 4:1 data selector, N bits wide.
module mux4 #(
    parameter int N = 8
) (
    input  logic [1:0]   sel_i,
    input  logic [N-1:0] d0_i,
    input  logic [N-1:0] d1_i,
    input  logic [N-1:0] d2_i,
    input  logic [N-1:0] d3_i,
    output logic [N-1:0] y_o
);

    assign y_o = sel_i[1] ? (sel_i[0] ? d3_i : d2_i) : (sel_i[0] ? d1_i : d0_i);

endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: four-source round-robin arbiter with a one-word registered output stage.
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [N-1:0]   d0,
    input  logic [N-1:0]   d1,
    input  logic [N-1:0]   d2,
    input  logic [N-1:0]   d3,
    output logic [3:0]     gnt,
    output logic [1:0]     s,
    output logic [N-1:0]   y,
    output logic           y_valid,
    input  logic           y_ready
);

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [1:0]     s_q, s_d;
    logic [N-1:0]   y_q, y_d;
    logic [1:0]     win;
    logic [N-1:0]   mux_y;
    logic           load;

    assign win  = rr_pick(req, ptr_q);
    assign load = (|req) && (state_q == IDLE || y_ready);

    mux4 #(.N(N)) u_mux (
        .sel_i (win),
        .d0_i  (d0),
        .d1_i  (d1),
        .d2_i  (d2),
        .d3_i  (d3),
        .y_o   (mux_y)
    );

    // Gated by rst so a held request cannot raise gnt while reset is asserted.
    assign gnt = (load && !rst) ? (4'b0001 << win) : 4'b0000;

    always_comb begin
        state_d = load ? BUSY : ((state_q == BUSY && y_ready) ? IDLE : state_q);
        ptr_d   = load ? win + 2'd1 : ptr_q;
        s_d     = load ? win : s_q;
        y_d     = load ? mux_y : y_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'b00;
            s_q     <= 2'b00;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            y_q     <= y_d;
        end
    end

    assign y_valid = (state_q == BUSY);
    assign s       = s_q;
    assign y       = y_q;

endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: directed self-checking bench for rr_arb4.
module tb_rr_arb4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] d0, d1, d2, d3;
    logic [3:0] gnt;
    logic [1:0] s;
    logic [7:0] y;
    logic       y_valid;
    logic       y_ready;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] dv [4];

    always #5 clk = ~clk;

    rr_arb4 #(.N(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .gnt     (gnt),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'hA5; dv[3] = 8'h33;
        d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
        rst = 1'b1; req = 4'b1111; y_ready = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(y_valid), 32'h0);
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_s", 32'(s), 32'h0);

        @(negedge clk);
        rst = 1'b0; req = 4'b0100; #1;
        chk("single_gnt", 32'(gnt), 32'h4);
        @(negedge clk);
        req = 4'b0000; #1;
        chk("single_gnt_once", 32'(gnt), 32'h0);
        chk("single_y", 32'(y), 32'hA5);
        chk("single_s", 32'(s), 32'h2);
        chk("single_valid", 32'(y_valid), 32'h1);
        req = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("stall_gnt", 32'(gnt), 32'h0);
            chk("stall_y", 32'(y), 32'hA5);
            chk("stall_s", 32'(s), 32'h2);
        end

        rst = 1'b1; #1;
        @(negedge clk);
        rst = 1'b0; req = 4'b1111; y_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
            @(negedge clk); #1;
            chk("rr_s", 32'(s), 32'(i % 4));
            chk("rr_y", 32'(y), 32'(dv[i % 4]));
            chk("rr_valid", 32'(y_valid), 32'h1);
        end

        req = 4'b1000; #1;
        chk("pre_wrap_gnt", 32'(gnt), 32'h8);
        @(negedge clk);
        y_ready = 1'b0; req = 4'b0001; #1;
        chk("pre_wrap_s", 32'(s), 32'h3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("wrap_hold_gnt", 32'(gnt), 32'h0);
            chk("wrap_hold_y", 32'(y), 32'h33);
            chk("wrap_hold_s", 32'(s), 32'h3);
        end
        y_ready = 1'b1; #1;
        chk("wrap_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        req = 4'b0000; #1;
        chk("wrap_s", 32'(s), 32'h0);
        chk("wrap_y", 32'(y), 32'h11);

        @(negedge clk); #1;
        chk("drain_valid", 32'(y_valid), 32'h0);
        chk("drain_y", 32'(y), 32'h11);
        chk("drain_s", 32'(s), 32'h0);
        @(negedge clk); #1;
        chk("idle_ready_ignored", 32'(y_valid), 32'h0);
        req = 4'b1000; #1;
        chk("idle_gnt", 32'(gnt), 32'h8);
        @(negedge clk);
        req = 4'b0000; y_ready = 1'b0; #1;
        chk("idle_lat_valid", 32'(y_valid), 32'h1);
        chk("idle_lat_s", 32'(s), 32'h3);
        chk("idle_lat_y", 32'(y), 32'h33);

        req = 4'b1111; #2;
        rst = 1'b1; #1;
        chk("async_valid", 32'(y_valid), 32'h0);
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_y", 32'(y), 32'h0);
        chk("async_s", 32'(s), 32'h0);
        @(negedge clk);
        rst = 1'b0; y_ready = 1'b1; #1;
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        @(negedge clk); #1;
        chk("post_rst_s", 32'(s), 32'h0);
        chk("post_rst_y", 32'(y), 32'h11);
        chk("post_rst_next_gnt", 32'(gnt), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
